// File: rtl/tag_gate_ctrl.sv
// Tag gate controller: forwards time-tagged events only inside a time window
// opened by a qualifying start tag.
//
// Parameters
//   TIME_W : tag time width (1/3 ps units)
//   CNT_W  : width of the forwarded-tag counter
// Ports
//   clk, rst_n              : clock, async active-low reset
//   cfg_arm, cfg_abort      : one-cycle arm / abort requests
//   cfg_start_channel       : channel whose rising edge opens the window
//   cfg_duration            : window length in tag time units
//   valid_tag, tagtime,
//   channel, rising_edge    : input tag stream
//   out_valid_tag, out_tagtime,
//   out_channel, out_rising_edge : gated tag stream, one cycle latency
//   state                   : 0 IDLE, 1 ARMED, 2 RUNNING, 3 DONE
//   gate_count              : tags forwarded in current/last window
//   window_done             : one-cycle pulse on normal window close
module tag_gate_ctrl #(
  parameter int unsigned TIME_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_arm,
  input  logic              cfg_abort,
  input  logic [4:0]        cfg_start_channel,
  input  logic [TIME_W-1:0] cfg_duration,
  input  logic              valid_tag,
  input  logic [TIME_W-1:0] tagtime,
  input  logic [4:0]        channel,
  input  logic              rising_edge,
  output logic              out_valid_tag,
  output logic [TIME_W-1:0] out_tagtime,
  output logic [4:0]        out_channel,
  output logic              out_rising_edge,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  gate_count,
  output logic              window_done
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArmed   = 2'd1;
  localparam logic [1:0] StRunning = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [TIME_W-1:0] end_time_q, end_time_d;
  logic [CNT_W-1:0]  gate_count_q, gate_count_d;
  logic              window_done_q, window_done_d;
  logic              out_valid_q, out_valid_d;
  logic [TIME_W-1:0] out_tagtime_q, out_tagtime_d;
  logic [4:0]        out_channel_q, out_channel_d;
  logic              out_rising_q, out_rising_d;

  logic              fwd;
  logic [TIME_W:0]   end_sum;
  logic [TIME_W-1:0] end_sat;

  // Extra carry bit detects overflow so the window end clamps at all-ones.
  assign end_sum = {1'b0, tagtime} + {1'b0, cfg_duration};
  assign end_sat = end_sum[TIME_W] ? {TIME_W{1'b1}} : end_sum[TIME_W-1:0];

  always_comb begin
    state_d      = state_q;
    end_time_d   = end_time_q;
    gate_count_d = gate_count_q;
    fwd          = 1'b0;
    if (cfg_abort) begin
      // Abort overrides everything, including a simultaneous arm or close.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (cfg_arm) state_d = StArmed;
        end
        StArmed: begin
          if (valid_tag && (channel == cfg_start_channel) && rising_edge) begin
            end_time_d   = end_sat;
            gate_count_d = CNT_W'(1);
            fwd          = 1'b1;
            state_d      = StRunning;
          end
        end
        StRunning: begin
          if (valid_tag) begin
            if (tagtime < end_time_q) begin
              fwd = 1'b1;
              if (gate_count_q != {CNT_W{1'b1}}) gate_count_d = gate_count_q + CNT_W'(1);
            end else begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    window_done_d = (state_d == StDone);
    out_valid_d   = fwd;
    out_tagtime_d = fwd ? tagtime     : out_tagtime_q;
    out_channel_d = fwd ? channel     : out_channel_q;
    out_rising_d  = fwd ? rising_edge : out_rising_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      end_time_q    <= '0;
      gate_count_q  <= '0;
      window_done_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_tagtime_q <= '0;
      out_channel_q <= '0;
      out_rising_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      end_time_q    <= end_time_d;
      gate_count_q  <= gate_count_d;
      window_done_q <= window_done_d;
      out_valid_q   <= out_valid_d;
      out_tagtime_q <= out_tagtime_d;
      out_channel_q <= out_channel_d;
      out_rising_q  <= out_rising_d;
    end
  end

  assign state           = state_q;
  assign gate_count      = gate_count_q;
  assign window_done     = window_done_q;
  assign out_valid_tag   = out_valid_q;
  assign out_tagtime     = out_tagtime_q;
  assign out_channel     = out_channel_q;
  assign out_rising_edge = out_rising_q;

endmodule

// File: tb/tb_tag_gate_ctrl.sv
module tb_tag_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_arm, cfg_abort;
  logic [4:0]  cfg_start_channel;
  logic [63:0] cfg_duration;
  logic        valid_tag;
  logic [63:0] tagtime;
  logic [4:0]  channel;
  logic        rising_edge;
  logic        out_valid_tag;
  logic [63:0] out_tagtime;
  logic [4:0]  out_channel;
  logic        out_rising_edge;
  logic [1:0]  state;
  logic [31:0] gate_count;
  logic        window_done;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] Ones = {64{1'b1}};

  tag_gate_ctrl #(.TIME_W(64), .CNT_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_arm           (cfg_arm),
    .cfg_abort         (cfg_abort),
    .cfg_start_channel (cfg_start_channel),
    .cfg_duration      (cfg_duration),
    .valid_tag         (valid_tag),
    .tagtime           (tagtime),
    .channel           (channel),
    .rising_edge       (rising_edge),
    .out_valid_tag     (out_valid_tag),
    .out_tagtime       (out_tagtime),
    .out_channel       (out_channel),
    .out_rising_edge   (out_rising_edge),
    .state             (state),
    .gate_count        (gate_count),
    .window_done       (window_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] t, input logic [4:0] ch,
                       input logic re);
    valid_tag   = v;
    tagtime     = t;
    channel     = ch;
    rising_edge = re;
  endtask

  task automatic arm_pulse();
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_arm = 0; cfg_abort = 0; cfg_start_channel = 0; cfg_duration = 0;
    drive(0, 0, 0, 0);
    #12;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    checks++; if (out_valid_tag !== 1'b0 || out_tagtime !== 64'd0 || out_channel !== 5'd0 ||
                  out_rising_edge !== 1'b0) begin
      errors++; $display("FAIL rst_out got v%0b t%0d c%0d e%0b exp zeros", out_valid_tag,
                         out_tagtime, out_channel, out_rising_edge);
    end
    checks++; if (gate_count !== 32'd0 || window_done !== 1'b0) begin
      errors++; $display("FAIL rst_cnt got %0d/%0b exp 0/0", gate_count, window_done);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (state !== 2'd0 || out_valid_tag !== 1'b0 || window_done !== 1'b0) begin
      errors++; $display("FAIL rst_release got s%0d v%0b d%0b exp 0", state, out_valid_tag,
                         window_done);
    end
  endtask

  task automatic test_normal();
    cfg_start_channel = 5'd1; cfg_duration = 64'd12000;
    arm_pulse();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL norm_armed got %0d exp 1", state); end
    drive(1, 4000, 1, 1); tick();
    checks++; if (out_valid_tag !== 1'b1 || out_tagtime !== 64'd4000 || gate_count !== 32'd1 ||
                  state !== 2'd2) begin
      errors++; $display("FAIL norm_start got v%0b t%0d n%0d s%0d exp 1 4000 1 2", out_valid_tag,
                         out_tagtime, gate_count, state);
    end
    // Config changes and a stray arm must not disturb the open window.
    cfg_duration = 0; cfg_start_channel = 5'd7; cfg_arm = 1'b1;
    drive(1, 8000, 0, 0); tick(); cfg_arm = 1'b0;
    checks++; if (out_valid_tag !== 1'b1 || out_tagtime !== 64'd8000 || out_channel !== 5'd0 ||
                  out_rising_edge !== 1'b0 || state !== 2'd2) begin
      errors++; $display("FAIL norm_t8000 got v%0b t%0d c%0d s%0d exp 1 8000 0 2", out_valid_tag,
                         out_tagtime, out_channel, state);
    end
    drive(0, 9000, 3, 1); tick();
    checks++; if (out_valid_tag !== 1'b0 || out_tagtime !== 64'd8000 || out_channel !== 5'd0) begin
      errors++; $display("FAIL norm_hold got v%0b t%0d c%0d exp 0 8000 0", out_valid_tag,
                         out_tagtime, out_channel);
    end
    drive(1, 15999, 2, 1); tick();
    checks++; if (out_valid_tag !== 1'b1 || out_tagtime !== 64'd15999 || out_channel !== 5'd2 ||
                  gate_count !== 32'd3) begin
      errors++; $display("FAIL norm_t15999 got v%0b t%0d n%0d exp 1 15999 3", out_valid_tag,
                         out_tagtime, gate_count);
    end
    drive(1, 16000, 0, 1); tick();
    checks++; if (out_valid_tag !== 1'b0 || state !== 2'd3 || window_done !== 1'b1) begin
      errors++; $display("FAIL norm_close got v%0b s%0d d%0b exp 0 3 1", out_valid_tag, state,
                         window_done);
    end
    drive(1, 17000, 1, 1); tick();
    checks++; if (state !== 2'd0 || window_done !== 1'b0 || gate_count !== 32'd3 ||
                  out_valid_tag !== 1'b0) begin
      errors++; $display("FAIL norm_idle got s%0d d%0b n%0d v%0b exp 0 0 3 0", state, window_done,
                         gate_count, out_valid_tag);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_start_qual();
    cfg_start_channel = 5'd2; cfg_duration = 64'd1000;
    arm_pulse();
    drive(1, 4000, 2, 0); tick();
    checks++; if (out_valid_tag !== 1'b0 || state !== 2'd1) begin
      errors++; $display("FAIL qual_fall got v%0b s%0d exp 0 1", out_valid_tag, state);
    end
    drive(1, 8000, 1, 1); tick();
    checks++; if (out_valid_tag !== 1'b0 || state !== 2'd1 || gate_count !== 32'd3) begin
      errors++; $display("FAIL qual_ch got v%0b s%0d n%0d exp 0 1 3", out_valid_tag, state,
                         gate_count);
    end
    drive(1, 12000, 2, 1); tick();
    checks++; if (out_valid_tag !== 1'b1 || out_tagtime !== 64'd12000 || gate_count !== 32'd1 ||
                  state !== 2'd2) begin
      errors++; $display("FAIL qual_open got v%0b t%0d n%0d s%0d exp 1 12000 1 2", out_valid_tag,
                         out_tagtime, gate_count, state);
    end
    drive(1, 13000, 2, 1); tick();
    checks++; if (out_valid_tag !== 1'b0 || state !== 2'd3 || window_done !== 1'b1) begin
      errors++; $display("FAIL qual_close got v%0b s%0d d%0b exp 0 3 1", out_valid_tag, state,
                         window_done);
    end
    drive(0, 0, 0, 0); tick();
  endtask

  task automatic test_abort();
    cfg_start_channel = 5'd1; cfg_duration = 64'd12000;
    arm_pulse();
    drive(1, 20000, 1, 1); tick();
    drive(1, 21000, 0, 1); tick();
    checks++; if (gate_count !== 32'd2) begin
      errors++; $display("FAIL abort_pre got %0d exp 2", gate_count);
    end
    cfg_abort = 1'b1; drive(1, 22000, 1, 1); tick(); cfg_abort = 1'b0;
    checks++; if (out_valid_tag !== 1'b0 || state !== 2'd0 || window_done !== 1'b0 ||
                  gate_count !== 32'd2 || out_tagtime !== 64'd21000) begin
      errors++; $display("FAIL abort got v%0b s%0d d%0b n%0d t%0d exp 0 0 0 2 21000",
                         out_valid_tag, state, window_done, gate_count, out_tagtime);
    end
    drive(1, 23000, 1, 1); tick();
    checks++; if (out_valid_tag !== 1'b0 || state !== 2'd0) begin
      errors++; $display("FAIL abort_idle got v%0b s%0d exp 0 0", out_valid_tag, state);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_dur_zero();
    cfg_start_channel = 5'd4; cfg_duration = 64'd0;
    arm_pulse();
    drive(1, 30000, 4, 1); tick();
    checks++; if (out_valid_tag !== 1'b1 || out_tagtime !== 64'd30000 || gate_count !== 32'd1) begin
      errors++; $display("FAIL dur0_start got v%0b t%0d n%0d exp 1 30000 1", out_valid_tag,
                         out_tagtime, gate_count);
    end
    drive(1, 30000, 1, 1); tick();
    checks++; if (out_valid_tag !== 1'b0 || state !== 2'd3 || window_done !== 1'b1) begin
      errors++; $display("FAIL dur0_close got v%0b s%0d d%0b exp 0 3 1", out_valid_tag, state,
                         window_done);
    end
    drive(0, 0, 0, 0); tick();
  endtask

  task automatic test_saturation();
    cfg_start_channel = 5'd1; cfg_duration = Ones;
    arm_pulse();
    drive(1, 4000, 1, 1); tick();
    drive(1, Ones - 64'd1, 0, 1); tick();
    checks++; if (out_valid_tag !== 1'b1 || out_tagtime !== Ones - 64'd1 ||
                  gate_count !== 32'd2) begin
      errors++; $display("FAIL sat_fwd got v%0b t%0h n%0d exp 1 %0h 2", out_valid_tag,
                         out_tagtime, gate_count, Ones - 64'd1);
    end
    drive(1, Ones, 0, 1); tick();
    checks++; if (out_valid_tag !== 1'b0 || state !== 2'd3) begin
      errors++; $display("FAIL sat_close got v%0b s%0d exp 0 3", out_valid_tag, state);
    end
    drive(0, 0, 0, 0); tick();
    cfg_arm = 1'b1; cfg_abort = 1'b1; tick(); cfg_arm = 1'b0; cfg_abort = 1'b0;
    checks++; if (state !== 2'd0) begin
      errors++; $display("FAIL arm_abort got %0d exp 0", state);
    end
  endtask

  task automatic test_reset_mid();
    cfg_start_channel = 5'd1; cfg_duration = 64'd100000;
    arm_pulse();
    drive(1, 40000, 1, 1); tick();
    drive(1, 41000, 0, 1); tick();
    checks++; if (out_valid_tag !== 1'b1 || gate_count !== 32'd2) begin
      errors++; $display("FAIL rmid_pre got v%0b n%0d exp 1 2", out_valid_tag, gate_count);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || out_valid_tag !== 1'b0 || out_tagtime !== 64'd0 ||
                  out_channel !== 5'd0 || out_rising_edge !== 1'b0 || gate_count !== 32'd0 ||
                  window_done !== 1'b0) begin
      errors++; $display("FAIL rmid_async got s%0d v%0b t%0d n%0d exp zeros", state,
                         out_valid_tag, out_tagtime, gate_count);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    drive(1, 42000, 1, 1); tick();
    checks++; if (out_valid_tag !== 1'b0 || state !== 2'd0 || window_done !== 1'b0) begin
      errors++; $display("FAIL rmid_after got v%0b s%0d d%0b exp 0 0 0", out_valid_tag, state,
                         window_done);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [1:0]  m_state = 2'd0;
    logic [63:0] m_end = 0, m_start = 0, t = 64'd100000;
    logic [31:0] m_cnt = 0;
    logic        efwd, v, re, arm;
    logic [4:0]  ch;
    cfg_start_channel = 5'd1; cfg_duration = 64'd20000;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 1) == 1);
      ch  = 5'($urandom_range(0, 2));
      re  = ($urandom_range(0, 1) == 1);
      arm = (m_state == 2'd0) && ($urandom_range(0, 3) == 0);
      t   = t + 64'd4000;
      drive(v, t, ch, re);
      cfg_arm = arm;
      efwd = 1'b0;
      case (m_state)
        2'd0: if (arm) m_state = 2'd1;
        2'd1: if (v && ch == 5'd1 && re) begin
          efwd = 1'b1; m_start = t; m_end = t + 64'd20000; m_cnt = 1; m_state = 2'd2;
        end
        2'd2: if (v) begin
          if (t < m_end) begin efwd = 1'b1; m_cnt++; end
          else m_state = 2'd3;
        end
        default: m_state = 2'd0;
      endcase
      tick();
      checks++;
      if (out_valid_tag !== efwd || gate_count !== m_cnt || state !== m_state ||
          (efwd && (out_tagtime !== t || out_channel !== ch || out_rising_edge !== re ||
                    out_tagtime < m_start || out_tagtime >= m_end))) begin
        errors++;
        $display("FAIL rand[%0d] got v%0b t%0d c%0d n%0d s%0d exp v%0b t%0d c%0d n%0d s%0d", i,
                 out_valid_tag, out_tagtime, out_channel, gate_count, state, efwd, t, ch,
                 m_cnt, m_state);
      end
    end
    cfg_arm = 1'b0;
    drive(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_start_qual();
    test_abort();
    test_dur_zero();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
